pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Central pipeline sequencer for the 5-stage ARM core (IF/ID/EX/MEM/WB).
//  Merges the hazard-detect stall, EX-stage branch redirect, multi-cycle data-memory wait and
//  retiring-halt requests into per-stage write enables and bubble/flush controls.
//  Owns the run/wait/drain/halt/error state machine.
//  Sits beside hazard_detect and drives pipeline registers and the PC.
// PARAMETERS
//  DRAIN_CYCLES  4    cycles spent draining in-flight instrs after halt_req before HALTED
//  MEM_TIMEOUT   255  max consecutive MEM_WAIT cycles without dmem_ack before ERROR
//  CNT_W         32   width of perf counters (macro-enabled only)
// PORTS
//  clk           in   1      core clock
//  rst           in   1      synchronous, active-high reset
//  hz_stall      in   1      load-use/RAW stall request from hazard_detect
//  br_taken_ex   in   1      branch taken, resolved in EX this cycle
//  dmem_req      in   1      MEM stage holds a valid load/store
//  dmem_ack      in   1      data memory completes access this cycle
//  halt_req      in   1      halting instruction (swi exit) retiring in WB
//  pc_we         out  1      PC register write enable
//  ifid_we       out  1      IF/ID write enable
//  ifid_flush    out  1      load NOP into IF/ID (valid=0)
//  idex_we       out  1      ID/EX write enable
//  idex_bubble   out  1      load NOP into ID/EX
//  exmem_we      out  1      EX/MEM write enable
//  memwb_bubble  out  1      load NOP into MEM/WB
//  halted        out  1      core stopped, sticky until rst
//  mem_err       out  1      dmem timeout, sticky until rst
//  state_o       out  3      current FSM state (debug)
// BEHAVIOUR
//  - Synchronous rst, active-high. The state register resets to RUN and all counters reset to 0.
//    While rst=1, outputs are forced to: all *_we=0, ifid_flush=1, idex_bubble=1, memwb_bubble=1,
//    halted=0, mem_err=0.
//  - Only state and counters are registered; outputs are combinational from state and inputs.
//    Zero-cycle response.
//  - States: RUN, MEM_WAIT, DRAIN, HALTED, ERROR.
//  - Default RUN output: all we=1, flush/bubble=0.
//  - Priority, RUN and MEM_WAIT: mem_busy > halt_req > br_taken_ex > hz_stall.
//    mem_busy = dmem_req & ~dmem_ack.
//    - mem_busy:
//      - pc/ifid/idex/exmem_we=0, memwb_bubble=1.
//      - In RUN: go to MEM_WAIT, wait_cnt=1.
//      - In MEM_WAIT: wait_cnt++.
//      - If wait_cnt==MEM_TIMEOUT while still busy: go to ERROR.
//    - Ack: a cycle with dmem_ack=1 is a normal RUN cycle; MEM_WAIT returns to RUN.
//      Lower-priority requests are then evaluated in that same cycle.
//    - halt_req: go to DRAIN, drain_cnt=DRAIN_CYCLES-1. This cycle: pc_we=0, ifid_flush=1.
//      An EX branch is squashed (no redirect).
//    - br_taken_ex: pc_we=1 (target), ifid_we=1 with ifid_flush=1, idex_bubble=1.
//      hz_stall is ignored this cycle, because the stalled instruction is being squashed.
//    - hz_stall: pc_we=0, ifid_we=0, idex_bubble=1; EX/MEM/WB advance.
//  - DRAIN:
//    - Outputs: pc_we=0, ifid_flush=1, idex_bubble=1; EX and later advance.
//      mem_busy still freezes the pipe and pauses drain_cnt.
//    - drain_cnt==0 (and not busy): go to HALTED.
//    - br/hz/halt inputs are ignored.
//  - HALTED: all we=0, bubbles=1, halted=1. Exits only on rst.
//  - ERROR: as HALTED plus mem_err=1.
//  - Counter rules:
//    - wait_cnt is 8 bits min (clog2(MEM_TIMEOUT+1)) and saturates; it never wraps.
//    - drain_cnt is clog2(DRAIN_CYCLES) bits.
//  - rst mid-MEM_WAIT or mid-DRAIN returns to RUN next cycle with counters cleared.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined:
//    - Adds outputs stall_cycles, flush_cycles, memwait_cycles (CNT_W each).
//    - Each increments in cycles with hz_stall-applied, branch-flush, or mem_busy respectively.
//    - Counters are zeroed by rst, wrap modulo 2^CNT_W, and freeze in HALTED/ERROR.
//  Not defined: no counter ports and no counter logic.
// STRUCTURE
//  pipe_ctrl_pkg: enum pipe_state_e {RUN, MEM_WAIT, DRAIN, HALTED, ERROR};
//    default DRAIN_CYCLES/MEM_TIMEOUT localparams.
//  Sub-module pipe_perf_cnt (one instance per counter, CNT_W param), instantiated only under
//    PIPE_CTRL_PERF_EN.
// TESTING
//  1. rst=1 3 cycles, then release -> during reset all *_we=0 and bubbles=1;
//     the cycle after release: state_o=RUN, all we=1.
//  2. hz_stall=1 for 2 cycles -> pc_we=0, ifid_we=0, idex_bubble=1 both cycles;
//     exmem_we=1; resumes when stall drops.
//  3. br_taken_ex=1 together with hz_stall=1 -> pc_we=1, ifid_flush=1, idex_bubble=1 (stall ignored).
//  4. dmem_req=1, ack after 3 cycles -> MEM_WAIT 3 cycles, all front we=0, memwb_bubble=1;
//     ack cycle state RUN.
//     With MEM_TIMEOUT=4 and no ack -> ERROR, mem_err=1 sticky until rst.
//  5. halt_req=1 with br_taken_ex=1 -> no redirect; DRAIN for 4 cycles, then halted=1;
//     a mem_busy mid-drain extends the drain by its length.
//  6. PIPE_CTRL_PERF_EN: 2 stall, 1 flush and 3 wait cycles
//     -> stall_cycles=2, flush_cycles=1, memwait_cycles=3.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared state encoding, default timing constants and counter
//                width helpers for the pipeline sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    DRAIN    = 3'd2,
    HALTED   = 3'd3,
    ERROR    = 3'd4
  } pipe_state_e;

  localparam int unsigned c_DEF_DRAIN_CYCLES = 4;
  localparam int unsigned c_DEF_MEM_TIMEOUT  = 255;

  // Wait counter must hold MEM_TIMEOUT and is never narrower than a byte.
  function automatic int unsigned wait_cnt_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w < 8) ? 8 : w;
  endfunction

  // Drain counter counts DRAIN_CYCLES-1 down to 0; keep at least one bit.
  function automatic int unsigned drain_cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_perf_cnt
//  Description : Free-running event counter, cleared by rst, wraps modulo
//                2^CNT_W. One instance per pipeline performance event.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Advance by one on each qualifying event; natural wrap on overflow.
  always_comb begin
    count_d = count_q;
    if (inc_i) count_d = count_q + 1'b1;
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Pipeline sequencer for the 5-stage core. Merges hazard stall,
//                EX branch redirect, data-memory wait and retiring halt into
//                per-stage write enables and bubble/flush controls, and owns
//                the RUN/MEM_WAIT/DRAIN/HALTED/ERROR state machine.
//                Outputs are combinational from state and inputs.
//                Optional feature macro: PIPE_CTRL_PERF_EN adds stall, flush
//                and memory-wait performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = c_DEF_DRAIN_CYCLES,
  parameter int unsigned MEM_TIMEOUT  = c_DEF_MEM_TIMEOUT
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int unsigned CNT_W        = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hz_stall,
  input  logic       br_taken_ex,
  input  logic       dmem_req,
  input  logic       dmem_ack,
  input  logic       halt_req,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_we,
  output logic       idex_bubble,
  output logic       exmem_we,
  output logic       memwb_bubble,
  output logic       halted,
  output logic       mem_err,
  output logic [2:0] state_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles,
  output logic [CNT_W-1:0] memwait_cycles
`endif
);

  localparam int unsigned c_WAIT_W  = wait_cnt_width(MEM_TIMEOUT);
  localparam int unsigned c_DRAIN_W = drain_cnt_width(DRAIN_CYCLES);
  localparam logic [c_WAIT_W-1:0]  c_WAIT_LIMIT = c_WAIT_W'(MEM_TIMEOUT);
  localparam logic [c_DRAIN_W-1:0] c_DRAIN_INIT = c_DRAIN_W'(DRAIN_CYCLES - 1);

  pipe_state_e          state_q, state_d;
  logic [c_WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [c_DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic                 mem_busy;

  assign mem_busy = dmem_req & ~dmem_ack;
  assign state_o  = state_q;

  // Next-state, counter update and zero-latency pipeline controls.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    idex_we      = 1'b1;
    exmem_we     = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    halted       = 1'b0;
    mem_err      = 1'b0;
    if (rst) begin
      // Keep every stage frozen and empty while reset is held.
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end else begin
      case (state_q)
        RUN, MEM_WAIT: begin
          if (mem_busy) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            memwb_bubble = 1'b1;
            if (state_q == RUN) begin
              state_d    = MEM_WAIT;
              wait_cnt_d = c_WAIT_W'(1);
            end else if (wait_cnt_q >= c_WAIT_LIMIT) begin
              state_d    = ERROR;
            end else begin
              // Bounded by the limit above, so the count can never wrap.
              wait_cnt_d = wait_cnt_q + 1'b1;
            end
          end else begin
            // An ack cycle behaves exactly like an ordinary RUN cycle.
            state_d    = RUN;
            wait_cnt_d = '0;
            if (halt_req) begin
              // Stop fetching; any EX branch this cycle is squashed.
              pc_we       = 1'b0;
              ifid_flush  = 1'b1;
              state_d     = DRAIN;
              drain_cnt_d = c_DRAIN_INIT;
            end else if (br_taken_ex) begin
              // Redirect overrides the stall: the stalled instr is flushed.
              ifid_flush  = 1'b1;
              idex_bubble = 1'b1;
            end else if (hz_stall) begin
              pc_we       = 1'b0;
              ifid_we     = 1'b0;
              idex_bubble = 1'b1;
            end
          end
        end
        DRAIN: begin
          pc_we       = 1'b0;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (mem_busy) begin
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            memwb_bubble = 1'b1;
          end else if (drain_cnt_q == '0) begin
            state_d     = HALTED;
          end else begin
            drain_cnt_d = drain_cnt_q - 1'b1;
          end
        end
        default: begin
          // HALTED and ERROR: pipe stopped until reset.
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          idex_we      = 1'b0;
          exmem_we     = 1'b0;
          ifid_flush   = 1'b1;
          idex_bubble  = 1'b1;
          memwb_bubble = 1'b1;
          halted       = 1'b1;
          mem_err      = (state_q != HALTED);
          if (state_q != HALTED) state_d = ERROR;
        end
      endcase
    end
  end

  // State and counter registers; reset returns to RUN with counters clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic run_phase, stall_hit, flush_hit, busy_hit;

  // Events only count where they steer the pipe; HALTED/ERROR never count.
  assign run_phase = (state_q == RUN) || (state_q == MEM_WAIT);
  assign stall_hit = run_phase & ~mem_busy & ~halt_req & ~br_taken_ex & hz_stall;
  assign flush_hit = run_phase & ~mem_busy & ~halt_req & br_taken_ex;
  assign busy_hit  = (run_phase | (state_q == DRAIN)) & mem_busy;

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc_i(stall_hit), .count_o(stall_cycles)
  );
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc_i(flush_hit), .count_o(flush_cycles)
  );
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_memwait_cnt (
    .clk(clk), .rst(rst), .inc_i(busy_hit), .count_o(memwait_cycles)
  );
`endif

endmodule
`default_nettype wire
